// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg
// Shared constants for the pipeline skid register: the "no exception" code,
// the buffer-occupancy state encoding and the default PC shown when the
// stage holds nothing valid after reset or flush.
package pipe_skid_reg_pkg;

    localparam int EXC_NONE = 0;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// pipe_entry
// One stored beat {data, pc, exc, exc_code} packed as a flat word.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset, loads CLR_VAL
//   i_load   capture i_d at the next edge
//   i_clear  load CLR_VAL at the next edge; wins over i_load
//   i_d      word to capture
//   o_q      stored word
module pipe_entry #(
    parameter int           W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= CLR_VAL;
        end else if (i_clear) begin
            r_q <= CLR_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// Pipeline stage register with ready/valid on both sides, a head entry that
// drives the outputs and a skid entry that absorbs the beat accepted in the
// cycle downstream stalls. in_ready is registered, so upstream never sees a
// combinational path from out_ready.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | head valid, skid free
// ST_FULL  | head and skid valid, in_ready=0
//
// Ports:
//   clk, reset (async active-low), flush (sync, kills all beats)
//   in_valid/in_ready/in_data/in_pc/in_exc/in_exc_code   upstream side
//   out_valid/out_ready/out_data/out_pc/out_exc/out_exc_code  downstream side
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int              DATA_W   = 64,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_DEFAULT),
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_exc,
    input  logic [EXC_W-1:0]  in_exc_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_exc,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int ENT_W = DATA_W + PC_W + 1 + EXC_W;
    localparam logic [ENT_W-1:0] HEAD_CLR = {{DATA_W{1'b0}}, PC_RESET, 1'b0, {EXC_W{1'b0}}};

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_head_ld;
    logic             w_head_from_skid;
    logic             w_skid_ld;
    logic             w_skid_clr;
    logic [EXC_W-1:0] w_in_code;
    logic [ENT_W-1:0] w_in_word;
    logic [ENT_W-1:0] w_head_d;
    logic [ENT_W-1:0] w_head_q;
    logic [ENT_W-1:0] w_skid_q;

    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = r_in_ready;
    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Code is scrubbed on entry so a clear flag never carries a stale code.
    assign w_in_code = in_exc ? in_exc_code : EXC_W'(EXC_NONE);
    assign w_in_word = {in_data, in_pc, in_exc, w_in_code};
    assign w_head_d  = w_head_from_skid ? w_skid_q : w_in_word;

    always_comb begin
        w_state_nxt      = r_state;
        w_head_ld        = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        w_skid_clr       = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ST_ONE;
                        w_head_ld   = 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({w_in_xfer, w_out_xfer})
                        2'b10: begin
                            w_state_nxt = ST_FULL;
                            w_skid_ld   = 1'b1;
                        end
                        2'b01: w_state_nxt = ST_EMPTY;
                        2'b11: w_head_ld   = 1'b1;
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so no input beat can arrive.
                    if (w_out_xfer) begin
                        w_state_nxt      = ST_ONE;
                        w_head_ld        = 1'b1;
                        w_head_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

    pipe_entry #(
        .W       (ENT_W),
        .CLR_VAL (HEAD_CLR)
    ) u_head (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_head_ld),
        .i_clear (flush),
        .i_d     (w_head_d),
        .o_q     (w_head_q)
    );

    pipe_entry #(
        .W       (ENT_W),
        .CLR_VAL ({ENT_W{1'b0}})
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_skid_ld),
        .i_clear (w_skid_clr),
        .i_d     (w_in_word),
        .o_q     (w_skid_q)
    );

    assign out_data     = w_head_q[ENT_W-1 -: DATA_W];
    assign out_pc       = w_head_q[EXC_W+1 +: PC_W];
    assign out_exc      = w_head_q[EXC_W];
    assign out_exc_code = w_head_q[EXC_W-1:0];

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [31:0] in_pc = '0;
    logic        in_exc = 1'b0;
    logic [4:0]  in_exc_code = '0;
    logic        in_valid2 = 1'b0;

    logic        in_ready, out_valid, out_exc;
    logic [63:0] out_data;
    logic [31:0] out_pc;
    logic [4:0]  out_exc_code;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, out_exc2;
    logic [63:0] out_data2;
    logic [31:0] out_pc2;
    logic [4:0]  out_exc_code2;
    logic [3:0]  stall_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_pc(in_pc), .in_exc(in_exc), .in_exc_code(in_exc_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pc(out_pc), .out_exc(out_exc), .out_exc_code(out_exc_code),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter so saturation is reached in a few cycles.
    pipe_skid_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .in_pc(in_pc), .in_exc(in_exc), .in_exc_code(in_exc_code),
        .out_valid(out_valid2), .out_ready(1'b0), .out_data(out_data2),
        .out_pc(out_pc2), .out_exc(out_exc2), .out_exc_code(out_exc_code2),
        .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic        fl, iv, ordy;
        int          k;
        logic        ex;
        logic [4:0]  code;
        logic        e_ov, e_ir, chk_pl;
        logic [63:0] e_d;
        logic [31:0] e_pc;
        logic        e_ex;
        logic [4:0]  e_code;
        logic [15:0] e_st;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic logic [63:0] bd(input int k);
        return 64'hCAFE_0000_0000_0000 | 64'(k);
    endfunction

    function automatic logic [31:0] bp(input int k);
        return 32'h0000_3000 + 32'(4 * k);
    endfunction

    // ek < 0 means the head is expected in its cleared form.
    function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                                input int k, input logic ex, input logic [4:0] code,
                                input logic e_ov, input logic e_ir, input logic chk_pl,
                                input int ek, input logic e_ex, input logic [4:0] e_code,
                                input logic [15:0] e_st);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.k = k; v.ex = ex; v.code = code;
        v.e_ov = e_ov; v.e_ir = e_ir; v.chk_pl = chk_pl;
        v.e_d  = (ek < 0) ? 64'd0 : bd(ek);
        v.e_pc = (ek < 0) ? 32'h0000_3000 : bp(ek);
        v.e_ex = e_ex; v.e_code = e_code; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy,
                         input int k, input logic ex, input logic [4:0] code);
        flush = fl; in_valid = iv; out_ready = ordy;
        in_data = bd(k); in_pc = bp(k); in_exc = ex; in_exc_code = code;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = mk(0, 1, 1, i, 0, 0, 1, 1, 1, i, 0, 0, 0);
        vecs[8]  = mk(0, 1, 0,  8, 0,  7, 1, 0, 1,  7, 0, 0, 1);
        vecs[9]  = mk(0, 1, 0,  9, 0,  0, 1, 0, 1,  7, 0, 0, 2);
        vecs[10] = mk(0, 1, 0,  9, 0,  0, 1, 0, 1,  7, 0, 0, 3);
        vecs[11] = mk(0, 1, 0,  9, 0,  0, 1, 0, 1,  7, 0, 0, 4);
        vecs[12] = mk(0, 1, 1,  9, 0,  0, 1, 1, 1,  8, 0, 0, 4);
        vecs[13] = mk(0, 1, 1,  9, 0,  0, 1, 1, 1,  9, 0, 0, 4);
        vecs[14] = mk(0, 1, 1, 10, 0, 10, 1, 1, 1, 10, 0, 0, 4);
        vecs[15] = mk(0, 1, 1, 11, 1,  4, 1, 1, 1, 11, 1, 4, 4);
        vecs[16] = mk(0, 0, 1,  0, 0,  0, 0, 1, 0,  0, 0, 0, 4);
        vecs[17] = mk(0, 1, 0, 12, 0,  0, 1, 1, 1, 12, 0, 0, 4);
        vecs[18] = mk(0, 1, 0, 13, 1,  2, 1, 0, 1, 12, 0, 0, 5);
        vecs[19] = mk(1, 1, 0, 14, 1,  3, 0, 1, 1, -1, 0, 0, 6);
        vecs[20] = mk(0, 0, 1,  0, 0,  0, 0, 1, 1, -1, 0, 0, 6);
        vecs[21] = mk(0, 1, 1, 15, 0,  0, 1, 1, 1, 15, 0, 0, 6);
        vecs[22] = mk(0, 0, 1,  0, 0,  0, 0, 1, 0,  0, 0, 0, 6);

        #12;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_pc", 64'(out_pc), 64'h3000);
        chk("reset out_data", out_data, 64'd0);
        chk("reset out_exc_code", 64'(out_exc_code), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
        reset = 1'b1;
        step();
        chk("idle out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].k, vecs[i].ex, vecs[i].code);
            step();
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].e_st));
            chk($sformatf("v%0d exc_clean", i), 64'(!out_exc && (out_exc_code != 0)), 64'd0);
            if (vecs[i].chk_pl) begin
                chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_d);
                chk($sformatf("v%0d out_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
                chk($sformatf("v%0d out_exc", i), 64'(out_exc), 64'(vecs[i].e_ex));
                chk($sformatf("v%0d out_exc_code", i), 64'(out_exc_code), 64'(vecs[i].e_code));
            end
        end

        // Fill to FULL, then assert reset between edges.
        drive(0, 1, 0, 16, 0, 0);
        step();
        drive(0, 1, 0, 17, 0, 0);
        step();
        chk("prereset in_ready", 64'(in_ready), 64'd0);
        chk("prereset out_valid", 64'(out_valid), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("async out_valid", 64'(out_valid), 64'd0);
        chk("async in_ready", 64'(in_ready), 64'd1);
        chk("async out_pc", 64'(out_pc), 64'h3000);
        chk("async out_data", out_data, 64'd0);
        chk("async stall_cnt", 64'(stall_cnt), 64'd0);
        #2;
        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        step();
        chk("postreset out_valid", 64'(out_valid), 64'd0);
        drive(0, 1, 1, 18, 0, 0);
        step();
        chk("postreset out_data", out_data, bd(18));
        chk("postreset out_pc", 64'(out_pc), 64'(bp(18)));
        drive(0, 0, 1, 0, 0, 0);

        // Saturation on the narrow-counter instance, out_ready tied low.
        in_valid2 = 1'b1;
        repeat (15) step();
        chk("sat out_valid", 64'(out_valid2), 64'd1);
        chk("sat pre", 64'(stall_cnt2), 64'd14);
        repeat (4) step();
        chk("sat final", 64'(stall_cnt2), 64'hF);
        in_valid2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
